// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2
  } rxState_t;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned ARM_IDLE_TICKS = 16;
  // Four 10-bit characters at the oversample rate.
  localparam int unsigned TIMEOUT_TICKS  = 4 * 10 * OVERSAMPLE;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; popData always shows the head entry.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       pushData,
  input  logic                    pop,
  output logic [DATA_W-1:0]       popData,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [LVL_W-1:0]  count;
  logic              doPush;
  logic              doPop;

  assign empty  = (count == '0);
  assign full   = (count == LVL_W'(DEPTH));
  assign doPop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doPop) rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop)      count <= count + LVL_W'(1);
      else if (doPop && !doPush) count <= count - LVL_W'(1);
    end
  end

  assign popData = mem[rdPtr];
  assign level   = count;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick, line sync, idle-arm FSM and byte capture.
// Optional idle-FIFO timeout flag enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_W-1:0]              divisor,
  input  logic                          rx_pin,
  input  logic [DATA_W-1:0]             rx_data_in,
  input  logic                          rx_done_in,
  input  logic                          rd_ready,
  input  logic                          ovr_clr,
  output logic                          rx_tick,
  output logic                          rx_sync,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          armed
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic                          rx_timeout
`endif
);

  localparam int unsigned IDLE_W = $clog2(ARM_IDLE_TICKS + 1);

  rxState_t          state;
  rxState_t          stateNext;
  logic [IDLE_W-1:0] idleCnt;
  logic [IDLE_W-1:0] idleNext;
  logic [DIV_W-1:0]  baudCnt;
  logic [DIV_W-1:0]  divPrev;
  logic              syncMeta;
  logic              doneReg;
  logic              runOk;
  logic              divStable;
  logic              tickInt;
  logic              pushReq;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              dropByte;

  assign runOk     = en && (divisor != '0);
  assign divStable = (divisor == divPrev);
  assign tickInt   = runOk && divStable && (baudCnt == divisor);
  assign rx_tick   = tickInt && (state == RUN);

  // Baud counter; a divisor change restarts the count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baudCnt <= '0;
      divPrev <= '0;
    end else begin
      divPrev <= divisor;
      if (!runOk || !divStable || (baudCnt == divisor)) baudCnt <= '0;
      else                                                baudCnt <= baudCnt + DIV_W'(1);
    end
  end

  // Two-flop synchronizer and done-level history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta <= 1'b1;
      rx_sync  <= 1'b1;
      doneReg  <= 1'b0;
    end else begin
      syncMeta <= rx_pin;
      rx_sync  <= syncMeta;
      doneReg  <= rx_done_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      idleCnt <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= stateNext;
      idleCnt <= idleNext;
      armed   <= (stateNext == RUN);
    end
  end

  always_comb begin
    stateNext = state;
    idleNext  = idleCnt;
    if (!runOk) begin
      stateNext = OFF;
      idleNext  = '0;
    end else begin
      case (state)
        OFF: begin
          stateNext = ARM;
          idleNext  = '0;
        end
        ARM: begin
          if (tickInt) begin
            if (!rx_sync) begin
              idleNext = '0;
            end else if (idleCnt == IDLE_W'(ARM_IDLE_TICKS - 1)) begin
              stateNext = RUN;
              idleNext  = '0;
            end else begin
              idleNext = idleCnt + IDLE_W'(1);
            end
          end
        end
        RUN:     stateNext = RUN;
        default: stateNext = OFF;
      endcase
    end
  end

  assign pushReq  = rx_done_in && !doneReg && (state == RUN);
  assign rd_valid = !fifoEmpty;
  assign fifoPop  = rd_ready && rd_valid;
  assign dropByte = pushReq && fifoFull && !fifoPop;

  uart_rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushReq),
    .pushData (rx_data_in),
    .pop      (rd_ready),
    .popData  (rd_data),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (level)
  );

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overrun <= 1'b0;
    else if (dropByte) overrun <= 1'b1;
    else if (ovr_clr)  overrun <= 1'b0;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] toCnt;

  // Counts ticks while bytes sit unread; any FIFO activity restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt      <= '0;
      rx_timeout <= 1'b0;
    end else if (pushReq || fifoPop) begin
      toCnt      <= '0;
      rx_timeout <= 1'b0;
    end else if ((state == RUN) && tickInt && rd_valid && !rx_timeout) begin
      toCnt <= toCnt + TO_W'(1);
      if (toCnt == TO_W'(TIMEOUT_TICKS - 1)) rx_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a scoreboard checking popped bytes.
module tb_uart_rx_ctrl;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  divisor;
  logic              rx_pin;
  logic [DATA_W-1:0] rx_data_in;
  logic              rx_done_in;
  logic              rd_ready;
  logic              ovr_clr;
  logic              rx_tick;
  logic              rx_sync;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [3:0]        level;
  logic              overrun;
  logic              armed;
`ifdef UART_RX_TIMEOUT_EN
  logic              rx_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int ticks;
  logic [7:0] expQ[$];
  logic [7:0] fillBytes[8] = '{8'h55, 8'hA3, 8'h3C, 8'h96, 8'h01, 8'h80, 8'hFE, 8'h7E};

  uart_rx_ctrl #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .divisor    (divisor),
    .rx_pin     (rx_pin),
    .rx_data_in (rx_data_in),
    .rx_done_in (rx_done_in),
    .rd_ready   (rd_ready),
    .ovr_clr    (ovr_clr),
    .rx_tick    (rx_tick),
    .rx_sync    (rx_sync),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .overrun    (overrun),
    .armed      (armed)
`ifdef UART_RX_TIMEOUT_EN
    ,
    .rx_timeout (rx_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Rising edge of rx_done_in for one cycle; expected bytes are queued before the push.
  task automatic sendByte(input logic [7:0] b, input bit capture);
    if (capture) expQ.push_back(b);
    rx_data_in = b;
    rx_done_in = 1'b1;
    step(1);
    rx_done_in = 1'b0;
    step(1);
  endtask

  task automatic waitArmed(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (armed) break;
      step(1);
    end
    check(name, int'(armed), 1);
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!rd_valid) break;
      step(1);
    end
    rd_ready = 1'b0;
    check("drain_empty", int'(rd_valid), 0);
    check("drain_level", int'(level), 0);
  endtask

  // Scoreboard monitor: every pop handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%02h expected no byte", rd_data);
      end else begin
        check("pop_data", int'(rd_data), int'(expQ.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; divisor = '0; rx_pin = 1'b1;
    rx_data_in = '0; rx_done_in = 1'b0; rd_ready = 1'b0; ovr_clr = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    check("rst_rx_tick", int'(rx_tick), 0);
    check("rst_rx_sync", int'(rx_sync), 1);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_armed", int'(armed), 0);
`ifdef UART_RX_TIMEOUT_EN
    check("rst_timeout", int'(rx_timeout), 0);
`endif

    // Arming with divisor 3: no ticks forwarded while arming.
    divisor = 16'd3;
    en = 1'b1;
    ticks = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      ticks += int'(rx_tick);
    end
    check("arm_no_ticks", ticks, 0);
    check("arm_not_yet", int'(armed), 0);
    waitArmed(20, "arm_done");
    for (int i = 0; i < 8; i++) begin
      if (rx_tick) break;
      step(1);
    end
    check("run_tick_seen", int'(rx_tick), 1);
    step(1); check("run_tick_p1", int'(rx_tick), 0);
    step(1); check("run_tick_p2", int'(rx_tick), 0);
    step(1); check("run_tick_p3", int'(rx_tick), 0);
    step(1); check("run_tick_p4", int'(rx_tick), 1);

    // Synchronizer latency.
    rx_pin = 1'b0;
    step(1); check("sync_lat1", int'(rx_sync), 1);
    step(1); check("sync_lat2", int'(rx_sync), 0);
    rx_pin = 1'b1;
    step(2); check("sync_back", int'(rx_sync), 1);

    // Arm restart: a low tick mid-arming restarts the idle count.
    en = 1'b0;
    step(1); check("disable_armed", int'(armed), 0);
    en = 1'b1;
    step(42);
    rx_pin = 1'b0;
    step(4);
    rx_pin = 1'b1;
    step(50);
    check("restart_not_armed", int'(armed), 0);
    waitArmed(40, "restart_armed");

    // Fill, overflow, clear.
    foreach (fillBytes[i]) sendByte(fillBytes[i], 1'b1);
    check("fill_level", int'(level), 8);
    check("fill_head", int'(rd_data), 8'h55);
    check("fill_overrun", int'(overrun), 0);
    sendByte(8'hFF, 1'b0);
    check("ovf_overrun", int'(overrun), 1);
    check("ovf_level", int'(level), 8);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);

    // Drop and clear in the same cycle: set wins.
    rx_data_in = 8'hEE; rx_done_in = 1'b1; ovr_clr = 1'b1;
    step(1);
    rx_done_in = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", int'(overrun), 1);
    step(1);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    check("ovr_cleared2", int'(overrun), 0);

    // Full FIFO: simultaneous push and pop both succeed.
    expQ.push_back(8'h11);
    rx_data_in = 8'h11; rx_done_in = 1'b1; rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0; rx_done_in = 1'b0;
    check("fullpp_level", int'(level), 8);
    check("fullpp_overrun", int'(overrun), 0);
    check("fullpp_head", int'(rd_data), 8'hA3);
    step(1);
    drain();

    // Pop while empty is ignored.
    rd_ready = 1'b1;
    step(2);
    check("empty_pop_level", int'(level), 0);
    check("empty_pop_valid", int'(rd_valid), 0);
    rd_ready = 1'b0;

    // Push and pop together while not full.
    sendByte(8'h42, 1'b1);
    check("pp_level_before", int'(level), 1);
    expQ.push_back(8'h24);
    rx_data_in = 8'h24; rx_done_in = 1'b1; rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0; rx_done_in = 1'b0;
    check("pp_level_after", int'(level), 1);
    check("pp_head", int'(rd_data), 8'h24);
    step(1);
    drain();

    // Disable with bytes queued.
    sendByte(8'h10, 1'b1);
    sendByte(8'h20, 1'b1);
    sendByte(8'h30, 1'b1);
    en = 1'b0;
    step(2);
    check("off_armed", int'(armed), 0);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      ticks += int'(rx_tick);
    end
    check("off_no_ticks", ticks, 0);
    check("off_level", int'(level), 3);
    check("off_valid", int'(rd_valid), 1);
    check("off_head", int'(rd_data), 8'h10);
    sendByte(8'h99, 1'b0);
    check("off_no_capture", int'(level), 3);
    en = 1'b1;
    waitArmed(80, "rearm");
    drain();

`ifdef UART_RX_TIMEOUT_EN
    // One byte left unread long enough raises the timeout.
    sendByte(8'h77, 1'b1);
    step(2400);
    check("to_early", int'(rx_timeout), 0);
    for (int i = 0; i < 240; i++) begin
      if (rx_timeout) break;
      step(1);
    end
    check("to_set", int'(rx_timeout), 1);
    rd_ready = 1'b1; step(1); rd_ready = 1'b0;
    check("to_cleared", int'(rx_timeout), 0);
`endif

    // Asynchronous reset mid-cycle.
    sendByte(8'h5A, 1'b1);
    check("prerst_level", int'(level), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_rd_valid", int'(rd_valid), 0);
    check("arst_level", int'(level), 0);
    check("arst_rd_data", int'(rd_data), 0);
    check("arst_armed", int'(armed), 0);
    check("arst_rx_tick", int'(rx_tick), 0);
    check("arst_rx_sync", int'(rx_sync), 1);
    check("arst_overrun", int'(overrun), 0);
    expQ.delete();
    step(1);
    rst = 1'b0;
    step(1);

    check("scoreboard_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
